// File: rtl/uart_receiver_if.sv
// Purpose : host-side bundle for the UART receiver (rate/enable/line in, byte and status out).
// Latency : none, wires only.
// Backpressure: none; Rx_VALID is a single-cycle pulse the host must capture when it fires.
//   baud_select [2:0] rate select, 000=300 ... 111=115200
//   Rx_EN             receiver enable
//   RxD               asynchronous serial line, idle high
//   Rx_DATA     [7:0] last correctly received byte
//   Rx_VALID          one-cycle pulse when Rx_DATA takes a good frame
//   Rx_PERROR         parity error of the last completed frame
//   Rx_FERROR         stop-bit error of the last completed frame
//   Rx_BUSY           frame in progress
interface uart_receiver_if;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    // Host / line side.
    modport master (
        output baud_select, Rx_EN, RxD,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
    );

    // Receiver side.
    modport slave (
        input  baud_select, Rx_EN, RxD,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
    );
endinterface

// File: rtl/uart_receiver.sv
// Purpose : UART receiver, 8 data bits LSB first + even parity + 1 stop, 16x oversampled, mid-bit sampling.
// Latency : 2-cycle input synchronizer; byte and flags appear 1 clock after the mid-stop sample tick.
// Backpressure: none; Rx_VALID pulses for one cycle and Rx_DATA holds until the next good frame.
// Ports:
//   clk   system clock, rising edge
//   reset asynchronous, active-high
//   rx    uart_receiver_if.slave (baud_select, Rx_EN, RxD in; Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY out)
module uart_receiver #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave rx
);

    // Sample divisor = round(CLK_HZ / (16 * baud)), rounding halves up.
    function automatic int calc_div(input int baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam int D300    = calc_div(300);
    localparam int D1200   = calc_div(1200);
    localparam int D4800   = calc_div(4800);
    localparam int D9600   = calc_div(9600);
    localparam int D19200  = calc_div(19200);
    localparam int D38400  = calc_div(38400);
    localparam int D57600  = calc_div(57600);
    localparam int D115200 = calc_div(115200);

    // The slowest rate has the largest divisor; divisor-1 always fits in clog2(divisor) bits.
    localparam int CNT_W = $clog2(D300);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] baud_cnt;
    logic             sample_tick;

    logic             rx_meta;
    logic             rxs;

    state_t           state;
    logic [3:0]       samp;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             par_bit;
    logic             frame_perr;
    logic             frame_ferr;

    always_comb begin
        div_m1 = CNT_W'(D300 - 1);
        case (rx.baud_select)
            3'b000:  div_m1 = CNT_W'(D300 - 1);
            3'b001:  div_m1 = CNT_W'(D1200 - 1);
            3'b010:  div_m1 = CNT_W'(D4800 - 1);
            3'b011:  div_m1 = CNT_W'(D9600 - 1);
            3'b100:  div_m1 = CNT_W'(D19200 - 1);
            3'b101:  div_m1 = CNT_W'(D38400 - 1);
            3'b110:  div_m1 = CNT_W'(D57600 - 1);
            default: div_m1 = CNT_W'(D115200 - 1);
        endcase
    end

    assign sample_tick = rx.Rx_EN && (baud_cnt == div_m1);

    // Free-running 16x tick, parked at zero while disabled so enabling starts a clean period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (!rx.Rx_EN || sample_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx.RxD;
            rxs     <= rx_meta;
        end
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    assign frame_perr = par_bit ^ (^shift_reg);
    assign frame_ferr = ~rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            samp         <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            rx.Rx_DATA   <= '0;
            rx.Rx_VALID  <= 1'b0;
            rx.Rx_PERROR <= 1'b0;
            rx.Rx_FERROR <= 1'b0;
            rx.Rx_BUSY   <= 1'b0;
        end else begin
            rx.Rx_VALID <= 1'b0;
            if (!rx.Rx_EN) begin
                // Abort silently: data and flags keep their last values.
                state      <= IDLE;
                samp       <= '0;
                bit_idx    <= '0;
                rx.Rx_BUSY <= 1'b0;
            end else if (sample_tick) begin
                // Rx_BUSY is updated alongside every state change so it always equals (state != IDLE).
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state      <= START;
                            samp       <= '0;
                            rx.Rx_BUSY <= 1'b1;
                        end
                    end
                    START: begin
                        if (samp == 4'd7 && rxs) begin
                            // Line back high at mid-start: a glitch, not a frame.
                            state      <= IDLE;
                            samp       <= '0;
                            rx.Rx_BUSY <= 1'b0;
                        end else if (samp == 4'd15) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            samp    <= '0;
                        end else begin
                            samp <= samp + 4'd1;
                        end
                    end
                    DATA: begin
                        if (samp == 4'd7) begin
                            shift_reg[bit_idx] <= rxs;
                        end
                        if (samp == 4'd15) begin
                            if (bit_idx == 3'd7) begin
                                state <= PARITY;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                        samp <= samp + 4'd1;
                    end
                    PARITY: begin
                        if (samp == 4'd7) begin
                            par_bit <= rxs;
                        end
                        if (samp == 4'd15) begin
                            state <= STOP;
                        end
                        samp <= samp + 4'd1;
                    end
                    STOP: begin
                        if (samp == 4'd7) begin
                            // Finish at mid-stop so a back-to-back start edge half a bit later is caught.
                            rx.Rx_PERROR <= frame_perr;
                            rx.Rx_FERROR <= frame_ferr;
                            if (!frame_perr && !frame_ferr) begin
                                rx.Rx_DATA  <= shift_reg;
                                rx.Rx_VALID <= 1'b1;
                            end
                            state      <= IDLE;
                            samp       <= '0;
                            rx.Rx_BUSY <= 1'b0;
                        end else begin
                            samp <= samp + 4'd1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        samp       <= '0;
                        rx.Rx_BUSY <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
